// File: rtl/spi_master.sv
// rtl/spi_master.sv - byte-oriented SPI master engine with latched per-byte configuration
module spi_master #(
  parameter int DIV_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cfg,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        busy,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_l
);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [4:0]           edge_cnt_q, edge_cnt_d;
  logic                 cpha_q, cpha_d;
  logic                 keep_q, keep_d;
  logic                 lsb_q, lsb_d;
  logic [7:0]           tx_sh_q, tx_sh_d;
  logic [7:0]           rx_sh_q, rx_sh_d;
  logic                 sclk_d, mosi_d, cs_l_d, tx_ready_d, rx_valid_d;
  logic [7:0]           rx_data_d;
  logic [7:0]           load_byte;
  logic                 accept, tick, leading, sample;
  logic                 unused_cfg;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  assign accept     = tx_valid & tx_ready;
  assign tick       = (cnt_q == '0);
  assign busy       = (state_q != IDLE) | ~cs_l;
  assign unused_cfg = ^cfg[31:12];

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    edge_cnt_d = edge_cnt_q;
    cpha_d     = cpha_q;
    keep_d     = keep_q;
    lsb_d      = lsb_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    sclk_d     = sclk;
    mosi_d     = mosi;
    cs_l_d     = cs_l;
    rx_data_d  = rx_data;
    rx_valid_d = 1'b0;
    load_byte  = cfg[11] ? rev8(tx_data) : tx_data;
    leading    = ~edge_cnt_q[0];
    sample     = leading ^ cpha_q;
    case (state_q)
      IDLE: begin
        sclk_d = cfg[8];
        if (accept) begin
          div_d      = cfg[DIV_WIDTH-1:0];
          cnt_d      = cfg[DIV_WIDTH-1:0];
          cpha_d     = cfg[9];
          keep_d     = cfg[10];
          lsb_d      = cfg[11];
          edge_cnt_d = '0;
          cs_l_d     = 1'b0;
          state_d    = LEAD;
          // CPHA=0 needs the first bit on the wire before the first leading edge.
          if (!cfg[9]) begin
            mosi_d  = load_byte[7];
            tx_sh_d = {load_byte[6:0], 1'b0};
          end else begin
            tx_sh_d = load_byte;
          end
        end else if (!cs_l && !cfg[10]) begin
          cnt_d   = div_q;
          state_d = TRAIL;
        end
      end
      LEAD: begin
        if (tick) begin
          cnt_d   = div_q;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      SHIFT: begin
        if (edge_cnt_q == 5'd16) begin
          rx_valid_d = 1'b1;
          rx_data_d  = lsb_q ? rev8(rx_sh_q) : rx_sh_q;
          if (keep_q) begin
            state_d = IDLE;
          end else begin
            cnt_d   = div_q;
            state_d = TRAIL;
          end
        end else if (tick) begin
          cnt_d      = div_q;
          edge_cnt_d = edge_cnt_q + 5'd1;
          sclk_d     = ~sclk;
          if (sample) begin
            rx_sh_d = {rx_sh_q[6:0], miso};
          end else if (edge_cnt_q != 5'd15) begin
            mosi_d  = tx_sh_q[7];
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      TRAIL: begin
        if (tick) begin
          cs_l_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    tx_ready_d = (state_d == IDLE);
  end

  // State and output registers; reset aborts any transfer and releases chip select at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      edge_cnt_q <= '0;
      cpha_q     <= 1'b0;
      keep_q     <= 1'b0;
      lsb_q      <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      cs_l       <= 1'b1;
      tx_ready   <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      edge_cnt_q <= edge_cnt_d;
      cpha_q     <= cpha_d;
      keep_q     <= keep_d;
      lsb_q      <= lsb_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      sclk       <= sclk_d;
      mosi       <= mosi_d;
      cs_l       <= cs_l_d;
      tx_ready   <= tx_ready_d;
      rx_valid   <= rx_valid_d;
      rx_data    <= rx_data_d;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - scoreboard bench for spi_master with SPI slave model
module tb_spi_master;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cfg;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        busy;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic        cs_l;

  logic        loopback;
  logic        slave_miso = 1'b0;
  assign miso = loopback ? mosi : slave_miso;

  spi_master #(.DIV_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .cfg(cfg), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs_l(cs_l)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    int         at;
  } exp_t;
  exp_t exp_q[$];

  // transfer descriptor handed to the slave model
  logic [7:0] nxt_tx = 8'h00, nxt_reply = 8'h00;
  logic       nxt_cpol = 1'b0, nxt_cpha = 1'b0, nxt_lsb = 1'b0;
  int         load_req = 0;
  int         last_accept = 0;
  int         last_h = 1;
  logic       keep_watch = 1'b0;
  int         keep_viol = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic tbit(input logic [7:0] b, input logic lsb, input int i);
    logic [7:0] v;
    v = b;
    return lsb ? v[i] : v[7-i];
  endfunction

  // Scoreboard: every rx_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else if (rx_valid) begin
      if (exp_q.size() == 0) begin
        chk("rx_unexpected", {31'b0, rx_valid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rx_data", {24'b0, rx_data}, {24'b0, e.data});
        chk("rx_cycle", cyc, e.at);
      end
    end
    if (keep_watch && cs_l) keep_viol++;
  end

  // SPI slave: shifts reply bits out and captures MOSI according to the byte's mode.
  int         load_seen = 0;
  int         s_cnt = 100;
  logic       s_prev = 1'b0;
  logic [7:0] s_cap = 8'h00;
  always @(negedge clk) begin
    if (load_seen != load_req) begin
      load_seen  = load_req;
      s_cnt      = 0;
      s_prev     = nxt_cpol;
      s_cap      = 8'h00;
      slave_miso = tbit(nxt_reply, nxt_lsb, 0);
    end else if (sclk !== s_prev) begin
      logic lead;
      int   idx;
      logic [7:0] val;
      s_prev = sclk;
      s_cnt++;
      lead = (s_cnt % 2) == 1;
      if (s_cnt <= 16) begin
        if (lead != nxt_cpha) begin
          idx = (s_cnt - 1) / 2;
          s_cap[idx] = mosi;
        end else if (nxt_cpha) begin
          slave_miso = tbit(nxt_reply, nxt_lsb, (s_cnt - 1) / 2);
        end else if (s_cnt / 2 < 8) begin
          slave_miso = tbit(nxt_reply, nxt_lsb, s_cnt / 2);
        end
        if (s_cnt == 16) begin
          for (int i = 0; i < 8; i++) begin
            if (nxt_lsb) val[i] = s_cap[i];
            else val[7-i] = s_cap[i];
          end
          chk("slave_mosi_byte", {24'b0, val}, {24'b0, nxt_tx});
        end
      end
    end
  end

  task automatic set_cfg(input int div, input logic cpol, input logic cpha, input logic keep, input logic lsb);
    cfg = {20'b0, lsb, keep, cpha, cpol, 8'(div)};
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] reply);
    int n;
    int h;
    n = 0;
    while (tx_ready !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (tx_ready !== 1'b1) chk("send_ready_timeout", {31'b0, tx_ready}, 32'd1);
    h           = int'(cfg[7:0]) + 1;
    tx_data     = d;
    tx_valid    = 1'b1;
    last_accept = cyc + 1;
    last_h      = h;
    nxt_tx      = d;
    nxt_reply   = reply;
    nxt_cpol    = cfg[8];
    nxt_cpha    = cfg[9];
    nxt_lsb     = cfg[11];
    load_req++;
    exp_q.push_back('{loopback ? d : reply, last_accept + 17 * h + 1});
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
    chk("ready_low_after_accept", {31'b0, tx_ready}, 32'd0);
  endtask

  task automatic wait_ready(input int exp_cyc, input string name);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (tx_ready === 1'b1) chk(name, cyc, exp_cyc);
    else chk("ready_timeout", {31'b0, tx_ready}, 32'd1);
  endtask

  task automatic wait_rx();
    int n;
    n = 0;
    while (rx_valid !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (rx_valid !== 1'b1) chk("rx_timeout", {31'b0, rx_valid}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, n, h, edges, early;
    logic prev;
    logic [7:0] d, r;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    loopback = 1'b1;
    set_cfg(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_cs_l", {31'b0, cs_l}, 32'd1);
    chk("rst_sclk", {31'b0, sclk}, 32'd0);
    chk("rst_mosi", {31'b0, mosi}, 32'd0);
    chk("rst_tx_ready", {31'b0, tx_ready}, 32'd0);
    chk("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    chk("rst_rx_data", {24'b0, rx_data}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_tx_ready", {31'b0, tx_ready}, 32'd1);
    chk("post_rst_sclk", {31'b0, sclk}, {31'b0, cfg[8]});

    // mode 0, div 0, loopback
    send(8'hA5, 8'h00);
    wait_ready(last_accept + 18 * last_h + 1, "mode0_ready_cycle");
    chk("mode0_cs_l_high", {31'b0, cs_l}, 32'd1);

    // mode 3, div 3, slave replies 0x3C
    loopback = 1'b0;
    set_cfg(3, 1, 1, 0, 0);
    repeat (2) @(negedge clk);
    chk("mode3_sclk_idle", {31'b0, sclk}, 32'd1);
    send(8'hC3, 8'h3C);
    wait_ready(last_accept + 18 * last_h + 1, "mode3_ready_cycle");

    // lsb first, mode 0
    loopback = 1'b1;
    set_cfg(1, 0, 0, 0, 1);
    repeat (2) @(negedge clk);
    send(8'h01, 8'h00);
    chk("lsb_first_bit", {31'b0, mosi}, 32'd1);
    wait_ready(last_accept + 18 * last_h + 1, "lsb_ready_cycle");

    // cs_keep back-to-back
    loopback  = 1'b0;
    set_cfg(1, 0, 0, 1, 0);
    keep_viol = 0;
    @(negedge clk);
    send(8'h11, 8'hE7);
    keep_watch = 1'b1;
    wait_ready(last_accept + 17 * last_h + 1, "keep_ready_cycle");
    send(8'h22, 8'h4B);
    h = last_h;
    wait_rx();
    set_cfg(1, 0, 0, 0, 0);
    t0         = cyc;
    keep_watch = 1'b0;
    chk("keep_busy_held", {31'b0, busy}, 32'd1);
    n = 0;
    early = 0;
    while (cs_l !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
      if (cs_l === 1'b0 && busy !== 1'b1) early++;
    end
    chk("keep_release_cycle", cyc, t0 + 1 + h);
    chk("keep_busy_released", {31'b0, busy}, 32'd0);
    chk("keep_busy_tracks", early, 0);
    chk("keep_cs_never_high", keep_viol, 0);

    // reset mid-transfer at the 5th sclk edge
    loopback = 1'b1;
    set_cfg(2, 0, 0, 0, 0);
    @(negedge clk);
    send(8'h96, 8'h00);
    prev  = sclk;
    edges = 0;
    n     = 0;
    while (edges < 5 && n < 1000) begin
      @(negedge clk);
      n++;
      if (sclk !== prev) begin
        edges++;
        prev = sclk;
      end
    end
    chk("edges_before_reset", edges, 5);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_cs_l", {31'b0, cs_l}, 32'd1);
    chk("abort_sclk", {31'b0, sclk}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready_back", {31'b0, tx_ready}, 32'd1);
    repeat (60) @(negedge clk);
    send(8'h5A, 8'h00);
    wait_ready(last_accept + 18 * last_h + 1, "fresh_ready_cycle");

    // cfg change and stray tx_valid mid-transfer
    loopback = 1'b0;
    set_cfg(2, 0, 0, 0, 0);
    @(negedge clk);
    send(8'h3A, 8'hC5);
    repeat (10) @(negedge clk);
    set_cfg(5, 1, 1, 0, 0);
    tx_data  = 8'hEE;
    tx_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("ready_low_while_busy", {31'b0, tx_ready}, 32'd0);
    end
    tx_valid = 1'b0;
    wait_ready(last_accept + 18 * last_h + 1, "midcfg_ready_cycle");
    @(negedge clk);
    chk("new_cpol_idle", {31'b0, sclk}, 32'd1);
    send(8'h77, 8'h88);
    wait_ready(last_accept + 18 * last_h + 1, "newcfg_ready_cycle");

    // randomized transfers
    for (int k = 0; k < 16; k++) begin
      d = 8'($urandom);
      r = 8'($urandom);
      loopback = 1'($urandom_range(0, 1));
      set_cfg($urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
              1'($urandom_range(0, 1)));
      @(negedge clk);
      send(d, r);
      wait_ready(last_accept + 18 * last_h + 1, "rand_ready_cycle");
    end

    // maximum divider
    loopback = 1'b0;
    set_cfg(255, 0, 1, 0, 0);
    @(negedge clk);
    send(8'hB4, 8'h69);
    wait_ready(last_accept + 18 * last_h + 1, "maxdiv_ready_cycle");

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
